// File: rtl/dmem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_port_arbiter_if : two-master request/grant bus plus the shared d_mem port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_W     = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [1:0]            m0_mode;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [1:0]            m1_mode;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;

  logic                  mem_wr_en;
  logic [1:0]            mem_mode;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_mode, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_mode, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wr_en, mem_mode, mem_wr_addr, mem_rd_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_mode, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_mode, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wr_en, mem_mode, mem_wr_addr, mem_rd_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// dmem_port_arbiter : shares one d_mem port between CPU (M0) and debug (M1)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int RD_LATENCY   = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  dmem_port_arbiter_if.slave  bus
);

  localparam int c_burst_w = $clog2(MAX_BURST + 1);
  localparam int c_wait_w  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_burst_w-1:0] c_max_burst = c_burst_w'(MAX_BURST);
  localparam logic [c_wait_w-1:0]  c_starve    = c_wait_w'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  owner_t                 owner_q, owner_d, pick;
  logic [c_burst_w-1:0]   burst_q, burst_d, burst_inc;
  logic [c_wait_w-1:0]    wait1_q, wait1_d;
  logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0]  pipe_id_q, pipe_id_d;
  logic                   m0_gnt, m1_gnt, ret_vld, ret_id;

  assign m0_gnt = (owner_q == OWN0) && bus.m0_req;
  assign m1_gnt = (owner_q == OWN1) && bus.m1_req;

  // Starved M1 overrides the fixed M0 priority.
  always_comb begin
    if (bus.m1_req && (wait1_q >= c_starve)) pick = OWN1;
    else if (bus.m0_req)                     pick = OWN0;
    else if (bus.m1_req)                     pick = OWN1;
    else                                     pick = IDLE;
  end

  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    burst_inc = burst_q + c_burst_w'(1);
    case (owner_q)
      IDLE: begin
        owner_d = pick;
        burst_d = '0;
      end
      OWN0: begin
        if (m0_gnt) burst_d = burst_inc;
        if (!bus.m0_req || (m0_gnt && (burst_inc == c_max_burst))) begin
          burst_d = '0;
          owner_d = bus.m1_req ? OWN1 : pick;
        end
      end
      OWN1: begin
        if (m1_gnt) burst_d = burst_inc;
        if (!bus.m1_req || (m1_gnt && (burst_inc == c_max_burst))) begin
          burst_d = '0;
          owner_d = bus.m0_req ? OWN0 : pick;
        end
      end
      default: begin
        owner_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    wait1_d = '0;
    if (bus.m1_req && !m1_gnt)
      wait1_d = (wait1_q >= c_starve) ? c_starve : wait1_q + c_wait_w'(1);
  end

  // Read-return pipe: stage 0 takes this cycle's accepted read, top stage routes mem_rdata.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = (m0_gnt && !bus.m0_we) || (m1_gnt && !bus.m1_we);
    pipe_id_d[0]  = m1_gnt;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= IDLE;
      burst_q    <= '0;
      wait1_q    <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      wait1_q    <= wait1_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  assign ret_vld = pipe_vld_q[RD_LATENCY-1];
  assign ret_id  = pipe_id_q[RD_LATENCY-1];

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = ret_vld && !ret_id;
  assign bus.m1_rvalid = ret_vld && ret_id;
  assign bus.m0_rdata  = (ret_vld && !ret_id) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (ret_vld && ret_id)  ? bus.mem_rdata : '0;

  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_mode    = '0;
    bus.mem_wr_addr = '0;
    bus.mem_rd_addr = '0;
    bus.mem_wdata   = '0;
    if (m0_gnt) begin
      bus.mem_wr_en   = bus.m0_we;
      bus.mem_mode    = bus.m0_mode;
      bus.mem_wr_addr = bus.m0_addr;
      bus.mem_rd_addr = bus.m0_addr;
      bus.mem_wdata   = bus.m0_wdata;
    end else if (m1_gnt) begin
      bus.mem_wr_en   = bus.m1_we;
      bus.mem_mode    = bus.m1_mode;
      bus.mem_wr_addr = bus.m1_addr;
      bus.mem_rd_addr = bus.m1_addr;
      bus.mem_wdata   = bus.m1_wdata;
    end
  end

endmodule

`default_nettype wire
